// File: rtl/pgr_uart_rx_sampler.sv
// UART receiver: rxd synchroniser, start detection, 3-sample majority vote per bit,
// 5-8 bit de-framing with optional parity and first-stop-bit check, FIFO push.
module pgr_uart_rx_sampler #(
    parameter int unsigned OVERSAMPLE  = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       rxd,
    input  logic [1:0] uart_word_len,
    input  logic       uart_parity_en,
    input  logic       uart_parity_type,
    input  logic       uart_stop_len,
    input  logic       uart_mode,
    input  logic       rx_fifo_full,
    output logic [7:0] rx_fifo_wr_data,
    output logic       rx_fifo_wr_en,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_overrun_err,
    output logic       rx_busy
);
    localparam int unsigned PhW = $clog2(OVERSAMPLE);
    localparam logic [PhW-1:0] PhLast = PhW'(OVERSAMPLE - 1);
    localparam logic [PhW-1:0] PhS0   = PhW'(OVERSAMPLE / 2 - 1);
    localparam logic [PhW-1:0] PhS1   = PhW'(OVERSAMPLE / 2);
    localparam logic [PhW-1:0] PhVote = PhW'(OVERSAMPLE / 2 + 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [PhW-1:0]         ph_q, ph_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [1:0]             samp_q, samp_d;
    logic [7:0]             data_q, data_d;
    logic [1:0]             wl_q, wl_d;
    logic                   par_en_q, par_en_d;
    logic                   par_odd_q, par_odd_d;
    logic                   msb_q, msb_d;
    logic                   perr_q, perr_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic                   wr_en_q, wr_en_d;
    logic                   perr_out_q, perr_out_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;

    logic       rxd_s;
    logic       vote;
    logic [2:0] last_idx;
    logic [2:0] bit_idx;
    logic       par_exp;

    // uart_stop_len is unused: only the first stop bit is checked, a second one is idle line.
    logic unused_stop_len;
    assign unused_stop_len = uart_stop_len;

    assign rxd_s    = sync_q[SYNC_STAGES-1];
    assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s) | (samp_q[1] & rxd_s);
    assign last_idx = 3'd4 + {1'b0, wl_q};
    assign bit_idx  = msb_q ? (last_idx - cnt_q) : cnt_q;
    // Unused upper data bits stay 0, so the 8-bit reduction covers exactly N bits.
    assign par_exp  = par_odd_q ? ~(^data_q) : ^data_q;

    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[SYNC_STAGES-2:0], rxd};
        prev_d     = prev_q;
        ph_d       = ph_q;
        cnt_d      = cnt_q;
        samp_d     = samp_q;
        data_d     = data_q;
        wl_d       = wl_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        msb_d      = msb_q;
        perr_d     = perr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        perr_out_d = 1'b0;
        ferr_d     = 1'b0;
        ovr_d      = 1'b0;

        if (clk_en) begin
            prev_d = rxd_s;
            if (state_q != StIdle) begin
                ph_d = (ph_q == PhLast) ? '0 : ph_q + 1'b1;
                if (ph_q == PhS0) samp_d[0] = rxd_s;
                if (ph_q == PhS1) samp_d[1] = rxd_s;
            end
            unique case (state_q)
                StIdle: begin
                    if (prev_q && !rxd_s) begin
                        state_d   = StStart;
                        ph_d      = '0;
                        cnt_d     = '0;
                        data_d    = '0;
                        perr_d    = 1'b0;
                        wl_d      = uart_word_len;
                        par_en_d  = uart_parity_en;
                        par_odd_d = uart_parity_type;
                        msb_d     = uart_mode;
                    end
                end
                StStart: begin
                    if (ph_q == PhVote && vote) begin
                        state_d = StIdle;
                        ph_d    = '0;
                    end else if (ph_q == PhLast) begin
                        state_d = StData;
                    end
                end
                StData: begin
                    if (ph_q == PhVote) data_d[bit_idx] = vote;
                    if (ph_q == PhLast) begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == last_idx) state_d = par_en_q ? StParity : StStop;
                    end
                end
                StParity: begin
                    if (ph_q == PhVote) perr_d = (vote != par_exp);
                    if (ph_q == PhLast) state_d = StStop;
                end
                StStop: begin
                    if (ph_q == PhVote) begin
                        state_d    = StIdle;
                        ph_d       = '0;
                        cnt_d      = '0;
                        wr_data_d  = data_q;
                        wr_en_d    = ~rx_fifo_full;
                        ovr_d      = rx_fifo_full;
                        perr_out_d = perr_q;
                        ferr_d     = ~vote;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sync_q     <= '1;
            prev_q     <= 1'b1;
            ph_q       <= '0;
            cnt_q      <= '0;
            samp_q     <= '0;
            data_q     <= '0;
            wl_q       <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            msb_q      <= 1'b0;
            perr_q     <= 1'b0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            ph_q       <= ph_d;
            cnt_q      <= cnt_d;
            samp_q     <= samp_d;
            data_q     <= data_d;
            wl_q       <= wl_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            msb_q      <= msb_d;
            perr_q     <= perr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            perr_out_q <= perr_out_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_fifo_wr_data = wr_data_q;
    assign rx_fifo_wr_en   = wr_en_q;
    assign rx_parity_err   = perr_out_q;
    assign rx_frame_err    = ferr_q;
    assign rx_overrun_err  = ovr_q;
    assign rx_busy         = (state_q != StIdle);

endmodule

// File: tb/tb_pgr_uart_rx_sampler.sv
// Bench for pgr_uart_rx_sampler: directed frames drive rxd, expected completions are queued
// and a negedge monitor pops and compares them whenever the receiver pulses an output.
module tb_pgr_uart_rx_sampler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_en = 1'b0;
    logic       rxd = 1'b1;
    logic [1:0] uart_word_len = 2'd3;
    logic       uart_parity_en = 1'b0;
    logic       uart_parity_type = 1'b0;
    logic       uart_stop_len = 1'b0;
    logic       uart_mode = 1'b0;
    logic       rx_fifo_full = 1'b0;
    logic [7:0] rx_fifo_wr_data;
    logic       rx_fifo_wr_en;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_overrun_err;
    logic       rx_busy;

    typedef struct {
        logic [7:0] data;
        logic       wr;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [1:0] div = 2'd0;

    pgr_uart_rx_sampler #(
        .OVERSAMPLE (6),
        .SYNC_STAGES(2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clk_en          (clk_en),
        .rxd             (rxd),
        .uart_word_len   (uart_word_len),
        .uart_parity_en  (uart_parity_en),
        .uart_parity_type(uart_parity_type),
        .uart_stop_len   (uart_stop_len),
        .uart_mode       (uart_mode),
        .rx_fifo_full    (rx_fifo_full),
        .rx_fifo_wr_data (rx_fifo_wr_data),
        .rx_fifo_wr_en   (rx_fifo_wr_en),
        .rx_parity_err   (rx_parity_err),
        .rx_frame_err    (rx_frame_err),
        .rx_overrun_err  (rx_overrun_err),
        .rx_busy         (rx_busy)
    );

    always #5 clk = ~clk;

    // One clk_en tick every 4 clocks, changed on negedge so it is stable at posedge.
    initial begin
        forever begin
            @(negedge clk);
            div    = div + 2'd1;
            clk_en = (div == 2'd0);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic wait_tick();
        do @(posedge clk); while (!clk_en);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rxd = v;
        repeat (6) wait_tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                              input logic par_bit, input logic msb, input logic stop_v);
        send_bit(1'b0);
        for (int k = 0; k < nbits; k++) send_bit(msb ? d[nbits-1-k] : d[k]);
        if (par_en) send_bit(par_bit);
        send_bit(stop_v);
        rxd = 1'b1;
    endtask

    task automatic push(input logic [7:0] d, input logic wr, input logic perr, input logic ferr,
                        input logic ovr);
        exp_t e;
        e.data = d; e.wr = wr; e.perr = perr; e.ferr = ferr; e.ovr = ovr;
        exp_q.push_back(e);
    endtask

    // Monitor: any completion pulse is matched against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (rx_fifo_wr_en || rx_overrun_err || rx_parity_err || rx_frame_err)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_completion: got wr=%0b data=0x%02h perr=%0b ferr=%0b ovr=%0b, expected none",
                             rx_fifo_wr_en, rx_fifo_wr_data, rx_parity_err, rx_frame_err,
                             rx_overrun_err);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_en", 8'(rx_fifo_wr_en), 8'(e.wr));
                    if (e.wr) chk("wr_data", rx_fifo_wr_data, e.data);
                    chk("parity_err", 8'(rx_parity_err), 8'(e.perr));
                    chk("frame_err", 8'(rx_frame_err), 8'(e.ferr));
                    chk("overrun_err", 8'(rx_overrun_err), 8'(e.ovr));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset_wr_en", 8'(rx_fifo_wr_en), 8'h0);
        chk("reset_wr_data", rx_fifo_wr_data, 8'h00);
        chk("reset_busy", 8'(rx_busy), 8'h0);
        chk("reset_errs", {5'd0, rx_parity_err, rx_frame_err, rx_overrun_err}, 8'h00);
        rst_n = 1'b1;
        repeat (4) wait_tick();

        // 1: 8N1 LSB-first 0xA5
        push(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) wait_tick();

        // 2: 7 bits, even parity, 0x35 has four ones so the sent parity bit 1 is wrong
        uart_word_len = 2'd2; uart_parity_en = 1'b1; uart_parity_type = 1'b0;
        push(8'h35, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(8'h35, 7, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (3) wait_tick();

        // 2b: same frame, odd parity, bit 1 is correct
        uart_parity_type = 1'b1;
        push(8'h35, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h35, 7, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (3) wait_tick();

        // 3: glitch low for 2 ticks is a false start
        uart_word_len = 2'd3; uart_parity_en = 1'b0; uart_parity_type = 1'b0;
        rxd = 1'b0;
        repeat (2) wait_tick();
        rxd = 1'b1;
        wait_tick();
        chk("busy_during_false_start", 8'(rx_busy), 8'h1);
        repeat (8) wait_tick();
        chk("busy_after_false_start", 8'(rx_busy), 8'h0);

        // 4: stop bit 0 then break, no further frames
        push(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        rxd = 1'b0;
        repeat (40) wait_tick();
        chk("busy_during_break", 8'(rx_busy), 8'h0);
        rxd = 1'b1;
        repeat (6) wait_tick();

        // 5: 5 bits MSB-first, line bits 1,0,0,1,1 -> 0x13; then with FIFO full
        uart_word_len = 2'd0; uart_mode = 1'b1;
        push(8'h13, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h13, 5, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) wait_tick();
        rx_fifo_full = 1'b1;
        push(8'h13, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h13, 5, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) wait_tick();
        rx_fifo_full = 1'b0;
        chk("wr_data_held", rx_fifo_wr_data, 8'h13);

        // 6: reset mid-DATA of 0x55 abandons it; only 0xC3 is written
        uart_word_len = 2'd3; uart_mode = 1'b0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_after_mid_reset", 8'(rx_busy), 8'h0);
        rst_n = 1'b1;
        repeat (4) wait_tick();
        push(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1);

        // back-to-back 8N1 with no idle gap between stop and next start
        push(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        push(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        push(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (12) wait_tick();

        chk("pending_expectations", 8'(exp_q.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
